sd_audio_streamer: RTL and testbench

- Sits between sd_controller and audio_processing on clk_25mhz.
- Issues sequential 512-byte block reads to the SD card starting at a programmed address.
- Packs the returned bytes into a 1024-entry sample FIFO.
- Serves one 8-bit unsigned sample per sample_req pulse, so audio playback is decoupled from SD block latency.

---
 rtl/sd_audio_streamer_pkg.sv | 19 +
 rtl/sd_audio_streamer_if.sv | 36 +++
 rtl/sd_audio_streamer_sample_fifo.sv | 79 +++++++
 rtl/sd_audio_streamer.sv | 148 ++++++++++++++
 tb/tb_sd_audio_streamer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_audio_streamer_pkg.sv
// Shared types and constants for the SD-card audio streaming path.
package sd_audio_streamer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        ISSUE,
        RECV,
        NEXT,
        DRAIN
    } stream_state_e;

    localparam int unsigned SD_BLOCK_BYTES = 512;
    localparam int unsigned SAMPLE_W       = 8;
    localparam int unsigned SD_ADDR_W      = 32;
    localparam int unsigned BLK_CNT_W      = 24;
    localparam int unsigned FIFO_LVL_W     = 11;

endpackage

// File: rtl/sd_audio_streamer_if.sv
// Control, SD-controller and sample-pop signals of sd_audio_streamer.
interface sd_audio_streamer_if;
    import sd_audio_streamer_pkg::*;

    logic                  enable;
    logic [SD_ADDR_W-1:0]  start_addr;
    logic [BLK_CNT_W-1:0]  num_blocks;
    logic                  sd_ready;
    logic                  sd_byte_available;
    logic [SAMPLE_W-1:0]   sd_dout;
    logic                  sd_rd;
    logic [SD_ADDR_W-1:0]  sd_addr;
    logic                  sample_req;
    logic [SAMPLE_W-1:0]   sample_out;
    logic                  sample_valid;
    logic                  underflow;
    logic                  done;
    logic [FIFO_LVL_W-1:0] fifo_level;

    modport master (
        output enable, start_addr, num_blocks,
        output sd_ready, sd_byte_available, sd_dout,
        output sample_req,
        input  sd_rd, sd_addr,
        input  sample_out, sample_valid, underflow, done, fifo_level
    );

    modport slave (
        input  enable, start_addr, num_blocks,
        input  sd_ready, sd_byte_available, sd_dout,
        input  sample_req,
        output sd_rd, sd_addr,
        output sample_out, sample_valid, underflow, done, fifo_level
    );

endinterface

// File: rtl/sd_audio_streamer_sample_fifo.sv
// Single-clock FIFO with registered read (one-cycle latency) and occupancy count.
module sample_fifo #(
    parameter  int unsigned DEPTH = 1024,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             pop_valid_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        push_ok  = push_i && !full;
        pop_ok   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage left unreset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= pop_ok;
            if (pop_ok) begin
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push_i && full));
        end
    end

    assign pop_data_o  = rd_data_q;
    assign pop_valid_o = rd_valid_q;
    assign count_o     = count_q;
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/sd_audio_streamer.sv
// Streams sequential SD blocks into a sample FIFO and serves one byte per sample request.
module sd_audio_streamer
    import sd_audio_streamer_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = SD_BLOCK_BYTES,
    parameter int unsigned ADDR_STEP   = 512,
    parameter int unsigned FIFO_DEPTH  = 1024
) (
    input  logic clk_25mhz,
    input  logic reset,
    sd_audio_streamer_if.slave bus
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BC_W  = $clog2(BLOCK_BYTES);
    localparam logic [LVL_W-1:0] LVL_ISSUE_MAX = LVL_W'(FIFO_DEPTH - BLOCK_BYTES);
    localparam logic [BC_W-1:0]  LAST_BYTE     = BC_W'(BLOCK_BYTES - 1);

    stream_state_e        state_q, state_d;
    logic [SD_ADDR_W-1:0] sd_addr_q, sd_addr_d;
    logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [BLK_CNT_W-1:0] num_blocks_q, num_blocks_d;
    logic [BC_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic                 done_q, done_d;
    logic                 byte_av_q;
    logic                 underflow_q;

    logic                 sd_rd;
    logic                 push;
    logic                 pop;
    logic [LVL_W-1:0]     fifo_count;
    logic                 fifo_empty;
    logic [SAMPLE_W-1:0]  fifo_data;
    logic                 fifo_valid;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk_i       (clk_25mhz),
        .rst_i       (reset),
        .push_i      (push),
        .push_data_i (bus.sd_dout),
        .pop_i       (pop),
        .pop_data_o  (fifo_data),
        .pop_valid_o (fifo_valid),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q      <= IDLE;
            sd_addr_q    <= '0;
            blk_cnt_q    <= '0;
            num_blocks_q <= '0;
            byte_cnt_q   <= '0;
            done_q       <= 1'b0;
            byte_av_q    <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sd_addr_q    <= sd_addr_d;
            blk_cnt_q    <= blk_cnt_d;
            num_blocks_q <= num_blocks_d;
            byte_cnt_q   <= byte_cnt_d;
            done_q       <= done_d;
            byte_av_q    <= bus.sd_byte_available;
            underflow_q  <= underflow_q | (bus.sample_req & fifo_empty);
        end
    end

    always_comb begin
        state_d      = state_q;
        sd_addr_d    = sd_addr_q;
        blk_cnt_d    = blk_cnt_q;
        num_blocks_d = num_blocks_q;
        byte_cnt_d   = byte_cnt_q;
        done_d       = done_q;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    sd_addr_d    = bus.start_addr;
                    blk_cnt_d    = '0;
                    num_blocks_d = bus.num_blocks;
                    state_d      = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                // Also gates on sd_ready so a block still in flight after reset finishes first.
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (fifo_count <= LVL_ISSUE_MAX && bus.sd_ready) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                byte_cnt_d = '0;
                if (!bus.sd_ready) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (push) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                sd_addr_d = sd_addr_q + SD_ADDR_W'(ADDR_STEP);
                blk_cnt_d = blk_cnt_q + 1'b1;
                if (num_blocks_q != '0 && blk_cnt_d == num_blocks_q) begin
                    state_d = DRAIN;
                end else if (!bus.enable) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_SPACE;
                end
            end
            DRAIN: begin
                if (done_q && !bus.enable) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end else if (fifo_empty) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sd_rd = (state_q == ISSUE);
        push  = (state_q == RECV) && bus.sd_byte_available && !byte_av_q;
        pop   = bus.sample_req && !fifo_empty;
    end

    assign bus.sd_rd        = sd_rd;
    assign bus.sd_addr      = sd_addr_q;
    assign bus.sample_out   = fifo_data;
    assign bus.sample_valid = fifo_valid;
    assign bus.underflow    = underflow_q;
    assign bus.done         = done_q;
    assign bus.fifo_level   = FIFO_LVL_W'(fifo_count);

endmodule

// File: tb/tb_sd_audio_streamer.sv
// Directed self-checking bench for sd_audio_streamer with a simple SD controller model.
module tb_sd_audio_streamer;
    import sd_audio_streamer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #20 clk = ~clk;

    sd_audio_streamer_if bus();

    sd_audio_streamer #(
        .BLOCK_BYTES (512),
        .ADDR_STEP   (512),
        .FIFO_DEPTH  (1024)
    ) dut (
        .clk_25mhz (clk),
        .reset     (reset),
        .bus       (bus)
    );

    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int rd_base  = 0;
    logic rd_prev = 1'b0;
    logic [7:0] sb[$];
    logic [7:0] last_pop = 8'h00;

    // Counts sd_rd commands (rising edges).
    always @(posedge clk) begin
        rd_prev <= bus.sd_rd;
        if (bus.sd_rd && !rd_prev) rd_cnt <= rd_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int unsigned hold);
        bus.sd_dout           = d;
        bus.sd_byte_available = 1'b1;
        repeat (hold) tick();
        bus.sd_byte_available = 1'b0;
        tick();
    endtask

    task automatic wait_rd(input int unsigned budget, output bit seen);
        seen = 1'b0;
        for (int unsigned k = 0; k < budget && !seen; k++) begin
            if (bus.sd_rd === 1'b1) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        chk({tag, "_valid"}, 32'(bus.sample_valid), 1);
        chk({tag, "_data"}, 32'(bus.sample_out), 32'(e));
        chk({tag, "_level"}, 32'(bus.fifo_level), 32'(sb.size()));
        last_pop = e;
        tick();
        chk({tag, "_valid_low"}, 32'(bus.sample_valid), 0);
    endtask

    task automatic serve_block(input logic [31:0] exp_addr, input logic [7:0] seed,
                               input int unsigned n_bytes, input int unsigned n_simul,
                               input bit hold_some, input string tag);
        bit seen;
        logic [7:0] d;
        logic [7:0] e;
        int unsigned h;
        wait_rd(200, seen);
        chk({tag, "_rd_seen"}, 32'(seen), 1);
        if (!seen) return;
        chk({tag, "_addr"}, bus.sd_addr, exp_addr);
        bus.sd_ready = 1'b0;
        tick();
        chk({tag, "_rd_drop"}, 32'(bus.sd_rd), 0);
        for (int unsigned i = 0; i < n_bytes; i++) begin
            d = 8'(i) ^ seed;
            if (i < n_simul) begin
                e = sb.pop_front();
                bus.sample_req        = 1'b1;
                bus.sd_dout           = d;
                bus.sd_byte_available = 1'b1;
                tick();
                bus.sample_req        = 1'b0;
                bus.sd_byte_available = 1'b0;
                sb.push_back(d);
                chk({tag, "_simul_valid"}, 32'(bus.sample_valid), 1);
                chk({tag, "_simul_data"}, 32'(bus.sample_out), 32'(e));
                chk({tag, "_simul_level"}, 32'(bus.fifo_level), 32'(sb.size()));
                last_pop = e;
                tick();
            end else begin
                h = (hold_some && (i % 4 == 0)) ? 3 : 1;
                send_byte(d, h);
                sb.push_back(d);
            end
        end
        if (n_bytes == 512) bus.sd_ready = 1'b1;
    endtask

    initial begin
        reset                 = 1'b1;
        bus.enable            = 1'b0;
        bus.start_addr        = '0;
        bus.num_blocks        = '0;
        bus.sd_ready          = 1'b1;
        bus.sd_byte_available = 1'b0;
        bus.sd_dout           = '0;
        bus.sample_req        = 1'b0;
        repeat (3) tick();
        chk("rst_sd_rd", 32'(bus.sd_rd), 0);
        chk("rst_sd_addr", bus.sd_addr, 0);
        chk("rst_sample_out", 32'(bus.sample_out), 0);
        chk("rst_sample_valid", 32'(bus.sample_valid), 0);
        chk("rst_underflow", 32'(bus.underflow), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_level", 32'(bus.fifo_level), 0);
        reset = 1'b0;
        tick();

        // Two bounded blocks, some strobes held for several cycles, then full drain.
        bus.start_addr = 32'h0000_0400;
        bus.num_blocks = 24'd2;
        bus.enable     = 1'b1;
        serve_block(32'h0000_0400, 8'h00, 512, 0, 1'b1, "t1_b0");
        serve_block(32'h0000_0600, 8'h00, 512, 0, 1'b1, "t1_b1");
        repeat (20) tick();
        chk("t1_rd_count", 32'(rd_cnt), 2);
        chk("t1_full", 32'(bus.fifo_level), 1024);
        chk("t1_done_full", 32'(bus.done), 0);
        for (int i = 0; i < 1024; i++) begin
            pop_one("t1_pop");
            tick();
            tick();
            if (i == 1022) chk("t1_done_early", 32'(bus.done), 0);
        end
        tick();
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_empty", 32'(bus.fifo_level), 0);
        chk("t1_no_underflow", 32'(bus.underflow), 0);
        bus.enable = 1'b0;
        tick();
        tick();
        chk("t1_done_clear", 32'(bus.done), 0);

        // Unbounded stream with back-pressure, refill, and simultaneous push/pop.
        rd_base        = rd_cnt;
        bus.start_addr = 32'h0000_1000;
        bus.num_blocks = 24'd0;
        bus.enable     = 1'b1;
        serve_block(32'h0000_1000, 8'h5A, 512, 0, 1'b0, "t2_b0");
        serve_block(32'h0000_1200, 8'hA5, 512, 0, 1'b0, "t2_b1");
        repeat (40) tick();
        chk("t2_full", 32'(bus.fifo_level), 1024);
        chk("t2_no_third_rd", 32'(rd_cnt), 32'(rd_base + 2));
        for (int i = 0; i < 511; i++) pop_one("t2_pop");
        chk("t2_no_rd_511", 32'(rd_cnt), 32'(rd_base + 2));
        chk("t2_rd_low_511", 32'(bus.sd_rd), 0);
        pop_one("t2_pop");
        tick();
        chk("t2_refill_rd", 32'(bus.sd_rd), 1);
        chk("t2_half_level", 32'(bus.fifo_level), 512);
        serve_block(32'h0000_1400, 8'hC3, 512, 100, 1'b0, "t2_b2");
        repeat (10) tick();
        chk("t2_one_new_rd", 32'(rd_cnt), 32'(rd_base + 3));
        chk("t2_level_924", 32'(bus.fifo_level), 924);
        bus.enable = 1'b0;
        tick();
        for (int i = 0; i < 924; i++) pop_one("t2_drain");
        chk("t2_drained", 32'(bus.fifo_level), 0);

        // Underflow is sticky across later successful pops.
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        chk("t3_uf_valid", 32'(bus.sample_valid), 0);
        chk("t3_uf_flag", 32'(bus.underflow), 1);
        chk("t3_uf_hold", 32'(bus.sample_out), 32'(last_pop));
        tick();
        chk("t3_uf_sticky", 32'(bus.underflow), 1);
        bus.start_addr = 32'h0000_8000;
        bus.num_blocks = 24'd1;
        bus.enable     = 1'b1;
        serve_block(32'h0000_8000, 8'h11, 512, 0, 1'b0, "t3_b0");
        repeat (3) pop_one("t3_pop");
        chk("t3_uf_after_pops", 32'(bus.underflow), 1);

        // Reset clears underflow, then a reset lands mid-block.
        reset = 1'b1;
        tick();
        tick();
        sb.delete();
        chk("t4_uf_cleared", 32'(bus.underflow), 0);
        chk("t4_level_clr", 32'(bus.fifo_level), 0);
        bus.start_addr = 32'h0000_2000;
        bus.num_blocks = 24'd0;
        reset = 1'b0;
        serve_block(32'h0000_2000, 8'h3C, 200, 0, 1'b0, "t4_part");
        reset = 1'b1;
        for (int i = 0; i < 20; i++) send_byte(8'hE0 + 8'(i), 1);
        sb.delete();
        chk("t4_rst_sd_rd", 32'(bus.sd_rd), 0);
        chk("t4_rst_sd_addr", bus.sd_addr, 0);
        chk("t4_rst_sample_out", 32'(bus.sample_out), 0);
        chk("t4_rst_valid", 32'(bus.sample_valid), 0);
        chk("t4_rst_underflow", 32'(bus.underflow), 0);
        chk("t4_rst_done", 32'(bus.done), 0);
        chk("t4_rst_level", 32'(bus.fifo_level), 0);
        rd_base        = rd_cnt;
        bus.start_addr = 32'h0000_3000;
        reset          = 1'b0;
        for (int i = 0; i < 20; i++) send_byte(8'hF0 + 8'(i), 1);
        chk("t4_wait_ready_rd", 32'(rd_cnt), 32'(rd_base));
        chk("t4_stray_ignored", 32'(bus.fifo_level), 0);
        chk("t4_new_addr", bus.sd_addr, 32'h0000_3000);
        bus.sd_ready = 1'b1;
        serve_block(32'h0000_3000, 8'h77, 512, 0, 1'b0, "t4_blk");
        repeat (3) tick();
        chk("t4_level", 32'(bus.fifo_level), 512);
        repeat (3) pop_one("t4_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
